frame_capture_ctrl: RTL and testbench
=====================================

# frame_capture_ctrl

Parametrised single-frame capture controller for the camera/VGA pipeline. It takes the pixel stream and raster coordinates driven to the VGA controller, waits a programmable number of frames after being armed, then writes one rectangular window of one selected channel (or packed RGB565) into external frame memory. It then freezes the display and reports completion. It sits between the VGA controller outputs and the SRAM write port.

## Interface
- `H_START`, 0: first captured column (raster X).
- `V_START`, 0: first captured row (raster Y).
- `H_RES`, 640: window width in pixels, ≥1.
- `V_RES`, 480: window height in lines, ≥1.
- `PIX_W`, 10: width of each colour input.
- `DATA_W`, 16: memory data width, ≥PIX_W.
- `ADDR_W`, 20: memory address width.
- `SKIP_FRAMES`, 50: frame ticks ignored after arming, 0..65535.

Ports:
- `iCLK` in, 1: pixel clock, same clock as the VGA controller.
- `iRST` in, 1: reset, asynchronous, active-high.
- `iRed`, `iGreen`, `iBlue` in, PIX_W: pixel colour.
- `iX`, `iY` in, 13 each: raster coordinate of the current pixel.
- `iArm` in, 1: level; a rising edge starts a capture, and low aborts or clears the capture.
- `iChSel` in, 2: 0 selects red, 1 green, 2 blue, 3 RGB565 (see Configuration).
- `iBase` in, ADDR_W: memory base address of the window.
- `oMemAddr` out, ADDR_W: write address.
- `oMemData` out, DATA_W: write data.
- `oMemWE` out, 1: write strobe, one cycle per pixel.
- `oBusy` out, 1: high in WAIT and CAPTURE.
- `oFreeze` out, 1: high in CAPTURE and DONE; holds the displayed frame.
- `oDone` out, 1: high in DONE.

## Operation
- **New pixel:** (iX,iY) differs from the value registered on the previous cycle. The previous-coordinate registers reset to all ones.
- **Frame tick:** a new pixel whose coordinate equals (H_START,V_START).
- **In window:** H_START ≤ iX < H_START+H_RES and V_START ≤ iY < V_START+V_RES.
- **Arm edge:** iArm is high and was low on the previous cycle.
- **States:**
  - IDLE: on an arm edge, latch iChSel and iBase, clear the 16-bit frame counter, and go to WAIT.
  - WAIT: on each frame tick, if counter == SKIP_FRAMES go to CAPTURE and write that tick's pixel; otherwise increment the counter.
  - CAPTURE: every new pixel that is in the window produces one write. After writing pixel (H_START+H_RES−1, V_START+V_RES−1), go to DONE.
  - DONE: hold until iArm goes low.
- **iArm low:** from any state, go to IDLE on the next edge. Any write already registered completes; no further writes are issued.
- **Address:** iBase + (iX−H_START) + H_RES·(iY−V_START), computed in ADDR_W bits. Overflow wraps modulo 2^ADDR_W.
- **Data:** the selected channel, zero-extended to DATA_W (LSB-aligned).
- **Latched values:** iChSel and iBase changes after arming have no effect until the next arm edge.
- **Out-of-window pixels and repeated coordinates** (the same coordinate on consecutive cycles) never write.

## Timing
- Registered outputs: oMemAddr, oMemData and oMemWE are valid one cycle after the qualifying pixel's clock edge.
- oMemWE pulse: high for exactly one cycle per write.
- Throughput: one write per cycle maximum. Total writes per capture = H_RES·V_RES.
- State flags: oBusy, oFreeze and oDone follow the state register with no extra latency.
- Arm to WAIT: arm edge at cycle n gives oBusy=1 at n+1.
- Reset values: all outputs 0, state IDLE.
- Reset mid-capture: oMemWE drops immediately (asynchronously); no partial write is issued after release.
- Re-arm: requires iArm low for at least one cycle, then high.
- Simultaneous arm edge and frame tick in IDLE: the tick is not counted.

## Configuration
- Macro: `FRAME_CAP_RGB565_EN`.
- Defined: iChSel=3 produces {R[PIX_W−1:PIX_W−5], G[PIX_W−1:PIX_W−6], B[PIX_W−1:PIX_W−5]} in bits 15:0, with upper bits zero. This requires DATA_W ≥ 16 and PIX_W ≥ 6.
- Undefined: the packing logic is absent and iChSel=3 behaves as 0 (red).

## Test plan
All scenarios use H_START=2, V_START=1, H_RES=4, V_RES=3, SKIP_FRAMES=2, iBase=0x100, on an 8×5 raster with one pixel per cycle.

1. **Normal capture:** arm, run 4 frames → exactly 12 writes during the 3rd frame tick onward. Addresses are 0x100..0x10B in raster order, data = iRed, then oDone=1 and oFreeze=1.
2. **Green channel with repeated coordinates:** iChSel=1, each coordinate held 2 cycles → still 12 writes, data = iGreen.
3. **Abort:** iArm low in the middle of the capture (after write 5) → no further writes, oBusy=0 and oFreeze=0 the next cycle. Re-arm gives a full 12-write capture.
4. **Asynchronous reset:** iRST during CAPTURE → all outputs 0 immediately and state IDLE. Without a new arm edge there are no writes.
5. **RGB565 packing:** with FRAME_CAP_RGB565_EN, iChSel=3, R=0x3FF, G=0x000, B=0x3FF → oMemData=0xF81F. With the macro undefined → 0x03FF.
6. **Address wrap:** iBase=0xFFFFA, ADDR_W=20 → the 7th write goes to 0x00000.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// ------------------
// Single-frame capture controller placed between the VGA controller outputs
// and the SRAM write port. After the controller is armed, it skips a
// programmable number of frame ticks. It then writes one rectangular window
// of the selected colour channel into frame memory, freezes the display and
// reports completion.
//
// Optional feature: define FRAME_CAP_RGB565_EN to enable RGB565 packing on
// iChSel=3. Packing requires DATA_W >= 16 and PIX_W >= 6. When the macro is
// not defined, iChSel=3 selects the red channel.
//
// Ports
//   iCLK                    pixel clock, shared with the VGA controller
//   iRST                    asynchronous active-high reset
//   iRed/iGreen/iBlue       pixel colour, PIX_W bits each
//   iX/iY                   raster coordinate of the current pixel
//   iArm                    level input; a rising edge starts a capture,
//                           and a low level aborts or clears it
//   iChSel                  0 red, 1 green, 2 blue, 3 RGB565 (or red)
//   iBase                   memory base address of the window
//   oMemAddr/oMemData       registered write address and write data
//   oMemWE                  write strobe, one cycle per pixel
//   oBusy                   high in WAIT and CAPTURE
//   oFreeze                 high in CAPTURE and DONE
//   oDone                   high in DONE
//   oState                  debug view of the state register
//
// Handshake: oMemWE is a valid-only strobe. The memory port has no ready
// signal and must accept a write on every cycle in which oMemWE is high.
// The address and data are meaningful only while oMemWE is high.
module frame_capture_ctrl #(
  parameter int H_START     = 0,
  parameter int V_START     = 0,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PIX_W       = 10,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 20,
  parameter int SKIP_FRAMES = 50
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [PIX_W-1:0]  iRed,
  input  logic [PIX_W-1:0]  iGreen,
  input  logic [PIX_W-1:0]  iBlue,
  input  logic [12:0]       iX,
  input  logic [12:0]       iY,
  input  logic              iArm,
  input  logic [1:0]        iChSel,
  input  logic [ADDR_W-1:0] iBase,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  output logic              oMemWE,
  output logic              oBusy,
  output logic              oFreeze,
  output logic              oDone,
  output logic [1:0]        oState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Window bounds. The upper bounds are one bit wider than the coordinate
  // so that a window that ends exactly at 2^13 still compares correctly.
  localparam logic [13:0] X_LO   = 14'(H_START);
  localparam logic [13:0] X_HI   = 14'(H_START + H_RES);
  localparam logic [13:0] Y_LO   = 14'(V_START);
  localparam logic [13:0] Y_HI   = 14'(V_START + V_RES);
  localparam logic [12:0] X_ORG  = 13'(H_START);
  localparam logic [12:0] Y_ORG  = 13'(V_START);
  localparam logic [12:0] X_LAST = 13'(H_START + H_RES - 1);
  localparam logic [12:0] Y_LAST = 13'(V_START + V_RES - 1);
  localparam logic [15:0] SKIP   = 16'(SKIP_FRAMES);

  state_t            state;
  logic [12:0]       prevX;
  logic [12:0]       prevY;
  logic              armQ;
  logic [15:0]       frameCnt;
  logic [1:0]        chSelQ;
  logic [ADDR_W-1:0] baseQ;

  logic              newPix;
  logic              inWin;
  logic              frameTick;
  logic              isLast;
  logic              armEdge;
  logic [ADDR_W-1:0] offX;
  logic [ADDR_W-1:0] offY;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] pixData;

  assign newPix    = ({iX, iY} != {prevX, prevY});
  assign inWin     = ({1'b0, iX} >= X_LO) && ({1'b0, iX} < X_HI) &&
                     ({1'b0, iY} >= Y_LO) && ({1'b0, iY} < Y_HI);
  assign frameTick = newPix && (iX == X_ORG) && (iY == Y_ORG);
  assign isLast    = (iX == X_LAST) && (iY == Y_LAST);
  assign armEdge   = iArm && !armQ;

  // The address arithmetic is performed entirely in ADDR_W bits, so an
  // address beyond the top of memory wraps around to zero.
  assign offX   = ADDR_W'(iX) - ADDR_W'(H_START);
  assign offY   = ADDR_W'(iY) - ADDR_W'(V_START);
  assign wrAddr = baseQ + offX + ADDR_W'(H_RES) * offY;

  always_comb begin
    pixData = DATA_W'(iRed);
    case (chSelQ)
      2'd1:    pixData = DATA_W'(iGreen);
      2'd2:    pixData = DATA_W'(iBlue);
`ifdef FRAME_CAP_RGB565_EN
      2'd3:    pixData = DATA_W'({iRed[PIX_W-1 -: 5], iGreen[PIX_W-1 -: 6],
                                  iBlue[PIX_W-1 -: 5]});
`endif
      default: pixData = DATA_W'(iRed);
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      prevX    <= '1;
      prevY    <= '1;
      // The arm history resets high. A level that is already high when
      // reset is released does not count as a new arm edge.
      armQ     <= 1'b1;
      frameCnt <= '0;
      chSelQ   <= '0;
      baseQ    <= '0;
      oMemAddr <= '0;
      oMemData <= '0;
      oMemWE   <= 1'b0;
    end else begin
      prevX  <= iX;
      prevY  <= iY;
      armQ   <= iArm;
      oMemWE <= 1'b0;
      if (!iArm) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (armEdge) begin
              chSelQ   <= iChSel;
              baseQ    <= iBase;
              frameCnt <= '0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (frameTick) begin
              if (frameCnt == SKIP) begin
                // The tick pixel is the window origin and is the first write.
                oMemWE   <= 1'b1;
                oMemAddr <= wrAddr;
                oMemData <= pixData;
                state    <= isLast ? DONE : CAPTURE;
              end else begin
                frameCnt <= frameCnt + 16'd1;
              end
            end
          end
          CAPTURE: begin
            if (newPix && inWin) begin
              oMemWE   <= 1'b1;
              oMemAddr <= wrAddr;
              oMemData <= pixData;
              if (isLast) state <= DONE;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign oBusy   = (state == WAIT) || (state == CAPTURE);
  assign oFreeze = (state == CAPTURE) || (state == DONE);
  assign oDone   = (state == DONE);
  assign oState  = state;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Testbench for frame_capture_ctrl. The window is 4x3 at (2,1), with an
// 8x5 raster, one pixel per cycle, and two skipped frames.
module tb_frame_capture_ctrl;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int PIX_W  = 10;

  logic              iCLK;
  logic              iRST;
  logic [PIX_W-1:0]  iRed;
  logic [PIX_W-1:0]  iGreen;
  logic [PIX_W-1:0]  iBlue;
  logic [12:0]       iX;
  logic [12:0]       iY;
  logic              iArm;
  logic [1:0]        iChSel;
  logic [ADDR_W-1:0] iBase;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemData;
  logic              oMemWE;
  logic              oBusy;
  logic              oFreeze;
  logic              oDone;
  logic [1:0]        oState;

  frame_capture_ctrl #(
    .H_START(2), .V_START(1), .H_RES(4), .V_RES(3),
    .PIX_W(PIX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SKIP_FRAMES(2)
  ) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iX(iX), .iY(iY), .iArm(iArm), .iChSel(iChSel), .iBase(iBase),
    .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemWE(oMemWE),
    .oBusy(oBusy), .oFreeze(oFreeze), .oDone(oDone), .oState(oState)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] addr7;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  bit const_col = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge iCLK) begin
    if (oMemWE === 1'b1) begin
      wr_cnt++;
      if (wr_cnt == 7) addr7 = oMemAddr;
      if (exp_addr_q.size() == 0) begin
        check("spurious_we", 32'd1, 32'd0);
      end else begin
        check("wr_addr", 32'(oMemAddr), 32'(exp_addr_q.pop_front()));
        check("wr_data", 32'(oMemData), 32'(exp_data_q.pop_front()));
      end
    end
  end

  function automatic logic [PIX_W-1:0] red_of(input int x, input int y);
    return const_col ? 10'h3FF : 10'(256 + x * 16 + y);
  endfunction
  function automatic logic [PIX_W-1:0] green_of(input int x, input int y);
    return const_col ? 10'h000 : 10'(512 + x * 16 + y);
  endfunction
  function automatic logic [PIX_W-1:0] blue_of(input int x, input int y);
    return const_col ? 10'h3FF : 10'(768 + x * 16 + y);
  endfunction

  // Window pixels in raster order: index i is (2 + i%4, 1 + i/4), and its
  // address is base + i.
  task automatic push_exp(input int n, input logic [ADDR_W-1:0] base, input int ch);
    for (int i = 0; i < n; i++) begin
      int x;
      int y;
      logic [ADDR_W-1:0] a;
      x = 2 + i % 4;
      y = 1 + i / 4;
      a = base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      case (ch)
        1: exp_data_q.push_back(DATA_W'(green_of(x, y)));
        2: exp_data_q.push_back(DATA_W'(blue_of(x, y)));
        3: begin
`ifdef FRAME_CAP_RGB565_EN
          exp_data_q.push_back(16'hF81F);
`else
          exp_data_q.push_back(16'h03FF);
`endif
        end
        default: exp_data_q.push_back(DATA_W'(red_of(x, y)));
      endcase
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  task automatic arm(input logic [1:0] ch, input logic [ADDR_W-1:0] base);
    iArm = 1'b0;
    tick(1);
    iChSel = ch;
    iBase = base;
    iArm = 1'b1;
    tick(1);
  endtask

  task automatic drive_pix(input int x, input int y);
    iX = 13'(x);
    iY = 13'(y);
    iRed = red_of(x, y);
    iGreen = green_of(x, y);
    iBlue = blue_of(x, y);
  endtask

  // act: 0 none, 1 drop iArm, 2 pulse reset; applied at pixel (ax,ay) of frame af
  task automatic run_frames(input int n, input int hold, input int act,
                            input int af, input int ax, input int ay);
    for (int f = 0; f < n; f++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 8; x++)
          for (int h = 0; h < hold; h++) begin
            bit hit;
            drive_pix(x, y);
            hit = (act != 0) && (f == af) && (x == ax) && (y == ay) && (h == 0);
            if (hit && act == 1) iArm = 1'b0;
            if (hit && act == 2) begin
              check("t4_we_before_rst", 32'(oMemWE), 32'd1);
              #2 iRST = 1'b1;
              #1;
              check("t4_rst_we", 32'(oMemWE), 32'd0);
              check("t4_rst_addr", 32'(oMemAddr), 32'd0);
              check("t4_rst_data", 32'(oMemData), 32'd0);
              check("t4_rst_flags", {29'd0, oBusy, oFreeze, oDone}, 32'd0);
              check("t4_rst_state", 32'(oState), 32'd0);
              #2 iRST = 1'b0;
            end
            @(posedge iCLK);
            #1;
            if (hit && act == 1) begin
              check("t3_abort_busy", 32'(oBusy), 32'd0);
              check("t3_abort_freeze", 32'(oFreeze), 32'd0);
            end
          end
  endtask

  task automatic end_capture(input string tag, input int exp_wr, input int exp_state);
    tick(2);
    check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, "_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_state"}, 32'(oState), 32'(exp_state));
    check({tag, "_done"}, 32'(oDone), (exp_state == 3) ? 32'd1 : 32'd0);
    check({tag, "_freeze"}, 32'(oFreeze), (exp_state == 3) ? 32'd1 : 32'd0);
  endtask

  initial begin
    iRST = 1'b1;
    iArm = 1'b0;
    iChSel = 2'd0;
    iBase = '0;
    drive_pix(0, 0);
    tick(2);
    check("rst_outputs", {oMemAddr, oMemData[10:0], oMemWE}, 32'd0);
    check("rst_flags", {27'd0, oBusy, oFreeze, oDone, oState}, 32'd0);
    iRST = 1'b0;
    tick(2);
    check("idle_flags", {27'd0, oBusy, oFreeze, oDone, oState}, 32'd0);

    // 1: normal red capture; oBusy one cycle after the arm edge
    wr_cnt = 0;
    iChSel = 2'd0;
    iBase = 20'h00100;
    iArm = 1'b1;
    tick(1);
    check("t1_busy_after_arm", 32'(oBusy), 32'd1);
    check("t1_state_wait", 32'(oState), 32'd1);
    push_exp(12, 20'h00100, 0);
    run_frames(4, 1, 0, 0, 0, 0);
    end_capture("t1", 12, 3);
    check("t1_busy_done", 32'(oBusy), 32'd0);

    // 2: green, each coordinate held two cycles; later changes to the
    // select and base inputs are ignored
    wr_cnt = 0;
    arm(2'd1, 20'h00100);
    iChSel = 2'd2;
    iBase = 20'h00300;
    push_exp(12, 20'h00100, 1);
    run_frames(4, 2, 0, 0, 0, 0);
    end_capture("t2", 12, 3);

    // 3: abort while pixel (3,2) is presented, after five writes; then re-arm
    wr_cnt = 0;
    arm(2'd0, 20'h00100);
    push_exp(5, 20'h00100, 0);
    run_frames(4, 1, 1, 2, 3, 2);
    end_capture("t3", 5, 0);
    wr_cnt = 0;
    arm(2'd0, 20'h00100);
    push_exp(12, 20'h00100, 0);
    run_frames(4, 1, 0, 0, 0, 0);
    end_capture("t3_rearm", 12, 3);

    // 4: reset mid-capture; the held arm level is not an edge
    wr_cnt = 0;
    arm(2'd0, 20'h00100);
    push_exp(5, 20'h00100, 0);
    run_frames(4, 1, 2, 2, 4, 2);
    end_capture("t4", 5, 0);

    // 5: channel select 3 on a constant colour
    wr_cnt = 0;
    const_col = 1'b1;
    arm(2'd3, 20'h00100);
    push_exp(12, 20'h00100, 3);
    run_frames(4, 1, 0, 0, 0, 0);
    end_capture("t5", 12, 3);
    const_col = 1'b0;

    // 6: address wrap; the seventh write goes to 0x00000
    wr_cnt = 0;
    addr7 = '1;
    arm(2'd2, 20'hFFFFA);
    push_exp(12, 20'hFFFFA, 2);
    run_frames(4, 1, 0, 0, 0, 0);
    end_capture("t6", 12, 3);
    check("t6_addr7_wrap", 32'(addr7), 32'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
